pipe_stage_skid: RTL and testbench
==================================

# pipe_stage_skid

Parametrised inter-stage pipeline register for the five-stage core, the general successor to the fixed per-boundary stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB). It carries an opaque payload plus a write-enable side-band and an exception flag, and replaces the global stall wire with a valid/ready handshake. An optional 2-entry skid buffer makes `in_ready` a registered signal. A flush squashes all held entries, and an exception-tagged entry has its architectural write-enables masked off at capture.

## Interface
- `DATA_W`, 256: payload width (pc, npc, inst, rs1/rs2, alu_res, csr fields, etc., packed by the instantiating stage).
- `WE_W`, 3: number of side-effect enable bits (e.g. we_reg, we_mem, csr_we); all are masked when the entry carries an exception.
- `SKID`, 1: 1 selects the 2-entry skid buffer with registered `in_ready`; 0 selects a single register with combinational `in_ready`.
- `CNT_W`, 16: width of the saturating back-pressure counter.
- `clk` in 1: clock, rising edge.
- `rstn` in 1: asynchronous, active-low reset.
- `flush` in 1: synchronous squash of all held entries.
- `in_valid` in 1: upstream entry present.
- `in_ready` out 1: stage can accept this cycle.
- `in_data` in DATA_W: payload.
- `in_we` in WE_W: side-effect enables.
- `in_except` in 1: entry carries an exception.
- `out_valid` out 1: head entry present.
- `out_ready` in 1: downstream accepts the head.
- `out_data` out DATA_W: head payload.
- `out_we` out WE_W: head enables, already masked.
- `out_except` out 1: head exception flag.
- `occupancy` out 2: held entries, 0..2.
- `stall_cnt` out CNT_W: cycles with `out_valid && !out_ready`, saturating.

## Operation
- Accept event: `in_valid && in_ready`. Fire event: `out_valid && out_ready`.
- Write-enable masking at capture: stored `we` = `in_except ? 0 : in_we`. Payload and except bit are stored unmodified.
- States (SKID=1):
  - EMPTY: accept -> ONE (main loads the input).
  - ONE:
    - fire and accept -> ONE (main loads the input).
    - fire only -> EMPTY.
    - accept only -> TWO (skid loads the input).
    - neither -> ONE, holding.
  - TWO: `in_ready` = 0. Fire -> ONE (main loads skid, skid is cleared). No fire -> hold.
- `in_ready` (SKID=1) = state != TWO; a function of registered state only.
- SKID=0: single entry. `in_ready` = `!out_valid || out_ready`. `occupancy` is never 2.
- Flush:
  - Next state is EMPTY.
  - All entry valid, data, we and except fields are zeroed.
  - Flush beats a same-cycle accept: the input entry is dropped.
  - Upstream sees `in_ready` per current state and must treat its beat as squashed.
- Ordering is strictly FIFO; the skid entry never overtakes main.
- `stall_cnt` increments each cycle with `out_valid && !out_ready` and saturates at all-ones. It is cleared only by reset; flush does not clear it.
- Outputs are driven directly from the main entry registers; there is no combinational path from input to output.

## Timing
- Reset (`rstn` low, asynchronous): state EMPTY. `out_valid`=0, `out_data`=0, `out_we`=0, `out_except`=0, `occupancy`=0, `stall_cnt`=0. `in_ready`=1 (both SKID values).
- Latency: an entry accepted at edge N appears on `out_*` after edge N, i.e. visible in cycle N+1.
- Throughput: 1 entry/cycle sustained while `out_ready`=1.
- Back-pressure: the entry in flight when `out_ready` drops lands in skid; `in_ready` falls the following cycle.
- Reset asserted mid-transfer: all entries are lost, with no partial-state retention.
- Simultaneous flush and fire: the downstream sees the fire (output was valid that cycle); the stage is empty afterwards.

## Structure
- Shared package `pipe_pkg`: state enum `pipe_state_e` {EMPTY, ONE, TWO}, and entry struct `pipe_entry_t` parametrised via a localparam-sized typedef per instance, or flat vectors if the tool forbids it.
- Sub-module `pipe_slot`: one entry register (valid, data, we, except) with load, clear and async reset. Instantiated twice (main, skid), or once when SKID=0.
- Control FSM, masking and counter live in `pipe_stage_skid`.

## Test plan
- Reset, then stream 8 entries with `out_ready`=1 -> outputs match inputs 1 cycle later in order; `occupancy`=1 steady; `stall_cnt`=0.
- Accept A, B, then `out_ready`=0 for 3 cycles -> `occupancy`=2, `in_ready`=0 from the cycle after B; `stall_cnt`=3; release -> A then B emitted, `in_ready` back to 1.
- `in_we`=3'b111 with `in_except`=1 -> `out_we`=3'b000, `out_except`=1, `out_data` unchanged; the next clean entry with `in_we`=3'b101 passes as 3'b101.
- State TWO, assert `flush` with `in_valid`=1 -> next cycle `out_valid`=0, `occupancy`=0, all outputs zero; the flushed-cycle input never appears.
- Drive `rstn` low asynchronously between edges while in state ONE -> outputs zero immediately, before the next edge; `stall_cnt`=0.
- SKID=0 instance: hold `out_ready`=0 -> `in_ready` = 0 in the same cycle `out_valid`=1; with CNT_W=4, 20 stalled cycles -> `stall_cnt`=15.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared types for the valid/ready pipeline stage register.
package pipe_pkg;

    localparam int unsigned OCC_W = 2;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } pipe_state_e;

    function automatic logic [OCC_W-1:0] state_occupancy(input pipe_state_e st);
        case (st)
            ONE:     return OCC_W'(1);
            TWO:     return OCC_W'(2);
            default: return OCC_W'(0);
        endcase
    endfunction

endpackage

// File: rtl/pipe_slot.sv
// One held pipeline entry: valid, payload, write-enables and exception flag.
module pipe_slot #(
    parameter int unsigned DATA_W = 256,
    parameter int unsigned WE_W   = 3
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              i_load,
    input  logic              i_clear,
    input  logic              i_valid,
    input  logic [DATA_W-1:0] i_data,
    input  logic [WE_W-1:0]   i_we,
    input  logic              i_except,
    output logic              o_valid,
    output logic [DATA_W-1:0] o_data,
    output logic [WE_W-1:0]   o_we,
    output logic              o_except
);

    logic              r_valid;
    logic [DATA_W-1:0] r_data;
    logic [WE_W-1:0]   r_we;
    logic              r_except;

    // Clear wins over load so a flush always leaves the slot zeroed.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_valid  <= 1'b0;
            r_data   <= '0;
            r_we     <= '0;
            r_except <= 1'b0;
        end else if (i_clear) begin
            r_valid  <= 1'b0;
            r_data   <= '0;
            r_we     <= '0;
            r_except <= 1'b0;
        end else if (i_load) begin
            r_valid  <= i_valid;
            r_data   <= i_data;
            r_we     <= i_we;
            r_except <= i_except;
        end
    end

    assign o_valid  = r_valid;
    assign o_data   = r_data;
    assign o_we     = r_we;
    assign o_except = r_except;

endmodule

// File: rtl/pipe_stage_skid.sv
// Inter-stage pipeline register with valid/ready handshake, optional 2-entry skid,
// flush, exception write-enable masking and a saturating back-pressure counter.
module pipe_stage_skid
    import pipe_pkg::*;
#(
    parameter int unsigned DATA_W = 256,
    parameter int unsigned WE_W   = 3,
    parameter int unsigned SKID   = 1,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [WE_W-1:0]   in_we,
    input  logic              in_except,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [WE_W-1:0]   out_we,
    output logic              out_except,
    output logic [OCC_W-1:0]  occupancy,
    output logic [CNT_W-1:0]  stall_cnt
);

    pipe_state_e       r_state;
    pipe_state_e       w_state_nxt;
    logic              w_accept;
    logic              w_fire;
    logic [WE_W-1:0]   w_in_we;
    logic              w_main_load;
    logic              w_main_from_skid;
    logic              w_main_clear;
    logic              w_skid_load;
    logic              w_skid_clear;
    logic              w_main_src_valid;
    logic [DATA_W-1:0] w_main_src_data;
    logic [WE_W-1:0]   w_main_src_we;
    logic              w_main_src_except;
    logic              w_skid_valid;
    logic [DATA_W-1:0] w_skid_data;
    logic [WE_W-1:0]   w_skid_we;
    logic              w_skid_except;
    logic [CNT_W-1:0]  r_stall_cnt;

    assign w_in_we  = in_except ? '0 : in_we;
    assign w_accept = in_valid && in_ready;
    assign w_fire   = out_valid && out_ready;
    assign in_ready = (SKID != 0) ? (r_state != TWO) : (!out_valid || out_ready);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_main_load      = 1'b0;
        w_main_from_skid = 1'b0;
        w_main_clear     = 1'b0;
        w_skid_load      = 1'b0;
        w_skid_clear     = 1'b0;
        if (flush) begin
            w_state_nxt  = EMPTY;
            w_main_clear = 1'b1;
            w_skid_clear = 1'b1;
        end else begin
            case (r_state)
                EMPTY: begin
                    if (w_accept) begin
                        w_state_nxt = ONE;
                        w_main_load = 1'b1;
                    end
                end
                ONE: begin
                    if (w_fire && w_accept) begin
                        w_main_load = 1'b1;
                    end else if (w_fire) begin
                        w_state_nxt  = EMPTY;
                        w_main_clear = 1'b1;
                    end else if (w_accept && (SKID != 0)) begin
                        w_state_nxt = TWO;
                        w_skid_load = 1'b1;
                    end
                end
                TWO: begin
                    if (w_fire) begin
                        w_state_nxt      = ONE;
                        w_main_load      = 1'b1;
                        w_main_from_skid = 1'b1;
                        w_skid_clear     = 1'b1;
                    end
                end
                default: begin
                    w_state_nxt = EMPTY;
                end
            endcase
        end
    end

    // Main refills from skid when draining TWO, otherwise from the (masked) input.
    assign w_main_src_valid  = w_main_from_skid ? w_skid_valid  : in_valid;
    assign w_main_src_data   = w_main_from_skid ? w_skid_data   : in_data;
    assign w_main_src_we     = w_main_from_skid ? w_skid_we     : w_in_we;
    assign w_main_src_except = w_main_from_skid ? w_skid_except : in_except;

    pipe_slot #(
        .DATA_W (DATA_W),
        .WE_W   (WE_W)
    ) u_main (
        .clk      (clk),
        .rstn     (rstn),
        .i_load   (w_main_load),
        .i_clear  (w_main_clear),
        .i_valid  (w_main_src_valid),
        .i_data   (w_main_src_data),
        .i_we     (w_main_src_we),
        .i_except (w_main_src_except),
        .o_valid  (out_valid),
        .o_data   (out_data),
        .o_we     (out_we),
        .o_except (out_except)
    );

    if (SKID != 0) begin : g_skid
        pipe_slot #(
            .DATA_W (DATA_W),
            .WE_W   (WE_W)
        ) u_skid (
            .clk      (clk),
            .rstn     (rstn),
            .i_load   (w_skid_load),
            .i_clear  (w_skid_clear),
            .i_valid  (in_valid),
            .i_data   (in_data),
            .i_we     (w_in_we),
            .i_except (in_except),
            .o_valid  (w_skid_valid),
            .o_data   (w_skid_data),
            .o_we     (w_skid_we),
            .o_except (w_skid_except)
        );
    end else begin : g_no_skid
        logic w_unused_skid;
        assign w_skid_valid  = 1'b0;
        assign w_skid_data   = '0;
        assign w_skid_we     = '0;
        assign w_skid_except = 1'b0;
        assign w_unused_skid = w_skid_load ^ w_skid_clear;
    end

    // Back-pressure counter survives flush; only reset clears it.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_stall_cnt <= '0;
        end else if (out_valid && !out_ready && (r_stall_cnt != {CNT_W{1'b1}})) begin
            r_stall_cnt <= r_stall_cnt + CNT_W'(1);
        end
    end

    assign occupancy = state_occupancy(r_state);
    assign stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed bench for pipe_stage_skid: table of per-cycle vectors on a SKID=1
// instance, plus hand sequences for async reset and a SKID=0, CNT_W=4 instance.
module tb_pipe_stage_skid;

    logic         clk;
    logic         rstn;

    logic         flush;
    logic         in_valid;
    logic         in_ready;
    logic [255:0] in_data;
    logic [2:0]   in_we;
    logic         in_except;
    logic         out_valid;
    logic         out_ready;
    logic [255:0] out_data;
    logic [2:0]   out_we;
    logic         out_except;
    logic [1:0]   occupancy;
    logic [15:0]  stall_cnt;

    logic         s0_flush;
    logic         s0_in_valid;
    logic         s0_in_ready;
    logic [15:0]  s0_in_data;
    logic [2:0]   s0_in_we;
    logic         s0_in_except;
    logic         s0_out_valid;
    logic         s0_out_ready;
    logic [15:0]  s0_out_data;
    logic [2:0]   s0_out_we;
    logic         s0_out_except;
    logic [1:0]   s0_occupancy;
    logic [3:0]   s0_stall_cnt;

    int n_cmp;
    int n_err;

    typedef struct {
        logic        iv;
        logic [31:0] din;
        logic [2:0]  we;
        logic        ex;
        logic        ordy;
        logic        fl;
        logic        ov;
        logic [31:0] dout;
        logic [2:0]  wout;
        logic        eout;
        logic [1:0]  occ;
        logic        irdy;
        logic [15:0] stall;
    } vec_t;

    vec_t vecs[$];

    pipe_stage_skid #(
        .DATA_W (256),
        .WE_W   (3),
        .SKID   (1),
        .CNT_W  (16)
    ) dut (
        .clk        (clk),
        .rstn       (rstn),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_we      (in_we),
        .in_except  (in_except),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_we     (out_we),
        .out_except (out_except),
        .occupancy  (occupancy),
        .stall_cnt  (stall_cnt)
    );

    pipe_stage_skid #(
        .DATA_W (16),
        .WE_W   (3),
        .SKID   (0),
        .CNT_W  (4)
    ) dut0 (
        .clk        (clk),
        .rstn       (rstn),
        .flush      (s0_flush),
        .in_valid   (s0_in_valid),
        .in_ready   (s0_in_ready),
        .in_data    (s0_in_data),
        .in_we      (s0_in_we),
        .in_except  (s0_in_except),
        .out_valid  (s0_out_valid),
        .out_ready  (s0_out_ready),
        .out_data   (s0_out_data),
        .out_we     (s0_out_we),
        .out_except (s0_out_except),
        .occupancy  (s0_occupancy),
        .stall_cnt  (s0_stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic add(input logic iv, input logic [31:0] din, input logic [2:0] we,
                       input logic ex, input logic ordy, input logic fl,
                       input logic ov, input logic [31:0] dout, input logic [2:0] wout,
                       input logic eout, input logic [1:0] occ, input logic irdy,
                       input logic [15:0] stall);
        vec_t v;
        v.iv = iv; v.din = din; v.we = we; v.ex = ex; v.ordy = ordy; v.fl = fl;
        v.ov = ov; v.dout = dout; v.wout = wout; v.eout = eout; v.occ = occ;
        v.irdy = irdy; v.stall = stall;
        vecs.push_back(v);
    endtask

    task automatic chk_dut_idle(input string tag);
        chk({tag, " out_valid"}, 256'(out_valid), 256'(0));
        chk({tag, " out_data"}, out_data, 256'(0));
        chk({tag, " out_we"}, 256'(out_we), 256'(0));
        chk({tag, " out_except"}, 256'(out_except), 256'(0));
        chk({tag, " occupancy"}, 256'(occupancy), 256'(0));
        chk({tag, " stall_cnt"}, 256'(stall_cnt), 256'(0));
        chk({tag, " in_ready"}, 256'(in_ready), 256'(1));
        chk({tag, " s0 out_valid"}, 256'(s0_out_valid), 256'(0));
        chk({tag, " s0 stall_cnt"}, 256'(s0_stall_cnt), 256'(0));
        chk({tag, " s0 in_ready"}, 256'(s0_in_ready), 256'(1));
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rstn = 1'b0;
        flush = 1'b0; in_valid = 1'b0; in_data = '0; in_we = '0; in_except = 1'b0;
        out_ready = 1'b0;
        s0_flush = 1'b0; s0_in_valid = 1'b0; s0_in_data = '0; s0_in_we = '0;
        s0_in_except = 1'b0; s0_out_ready = 1'b0;

        // 8-entry stream at full throughput, then drain
        for (int i = 0; i < 8; i++)
            add(1, 32'h1000_0000 + 32'(i), 3'(i), 0, 1, 0,
                1, 32'h1000_0000 + 32'(i), 3'(i), 0, 2'd1, 1, 16'd0);
        add(0, 32'h0, 3'b000, 0, 1, 0,  0, 32'h0, 3'b000, 0, 2'd0, 1, 16'd0);
        // A, B then back-pressure: B lands in skid, C refused
        add(1, 32'hAAAA_0001, 3'b001, 0, 0, 0,  1, 32'hAAAA_0001, 3'b001, 0, 2'd1, 1, 16'd0);
        add(1, 32'hBBBB_0002, 3'b010, 0, 0, 0,  1, 32'hAAAA_0001, 3'b001, 0, 2'd2, 0, 16'd1);
        add(1, 32'hCCCC_0003, 3'b011, 0, 0, 0,  1, 32'hAAAA_0001, 3'b001, 0, 2'd2, 0, 16'd2);
        add(0, 32'h0, 3'b000, 0, 0, 0,          1, 32'hAAAA_0001, 3'b001, 0, 2'd2, 0, 16'd3);
        add(0, 32'h0, 3'b000, 0, 1, 0,          1, 32'hBBBB_0002, 3'b010, 0, 2'd1, 1, 16'd3);
        add(0, 32'h0, 3'b000, 0, 1, 0,          0, 32'h0, 3'b000, 0, 2'd0, 1, 16'd3);
        // exception masks enables; clean entry passes unchanged
        add(1, 32'hEEEE_0004, 3'b111, 1, 1, 0,  1, 32'hEEEE_0004, 3'b000, 1, 2'd1, 1, 16'd3);
        add(1, 32'hFFFF_0005, 3'b101, 0, 1, 0,  1, 32'hFFFF_0005, 3'b101, 0, 2'd1, 1, 16'd3);
        add(0, 32'h0, 3'b000, 0, 1, 0,          0, 32'h0, 3'b000, 0, 2'd0, 1, 16'd3);
        // fill TWO, then flush with a concurrent input beat
        add(1, 32'h0102_0304, 3'b110, 0, 0, 0,  1, 32'h0102_0304, 3'b110, 0, 2'd1, 1, 16'd3);
        add(1, 32'h0506_0708, 3'b011, 1, 0, 0,  1, 32'h0102_0304, 3'b110, 0, 2'd2, 0, 16'd4);
        add(1, 32'h090A_0B0C, 3'b111, 0, 0, 1,  0, 32'h0, 3'b000, 0, 2'd0, 1, 16'd5);
        add(0, 32'h0, 3'b000, 0, 1, 0,          0, 32'h0, 3'b000, 0, 2'd0, 1, 16'd5);
        // flush coinciding with fire
        add(1, 32'h0D0E_0F10, 3'b001, 0, 1, 0,  1, 32'h0D0E_0F10, 3'b001, 0, 2'd1, 1, 16'd5);
        add(1, 32'h1112_1314, 3'b010, 0, 1, 1,  0, 32'h0, 3'b000, 0, 2'd0, 1, 16'd5);
        add(0, 32'h0, 3'b000, 0, 1, 0,          0, 32'h0, 3'b000, 0, 2'd0, 1, 16'd5);
        // leave one entry held for the async reset sequence
        add(1, 32'h1516_1718, 3'b100, 0, 0, 0,  1, 32'h1516_1718, 3'b100, 0, 2'd1, 1, 16'd5);

        #3;
        chk_dut_idle("reset");
        #9;
        rstn = 1'b1;
        @(posedge clk);
        #1;

        foreach (vecs[i]) begin
            in_valid  = vecs[i].iv;
            in_data   = 256'(vecs[i].din);
            in_we     = vecs[i].we;
            in_except = vecs[i].ex;
            out_ready = vecs[i].ordy;
            flush     = vecs[i].fl;
            @(posedge clk);
            #1;
            chk($sformatf("v%0d out_valid", i), 256'(out_valid), 256'(vecs[i].ov));
            chk($sformatf("v%0d out_data", i), out_data, 256'(vecs[i].dout));
            chk($sformatf("v%0d out_we", i), 256'(out_we), 256'(vecs[i].wout));
            chk($sformatf("v%0d out_except", i), 256'(out_except), 256'(vecs[i].eout));
            chk($sformatf("v%0d occupancy", i), 256'(occupancy), 256'(vecs[i].occ));
            chk($sformatf("v%0d in_ready", i), 256'(in_ready), 256'(vecs[i].irdy));
            chk($sformatf("v%0d stall_cnt", i), 256'(stall_cnt), 256'(vecs[i].stall));
        end

        // async reset between edges while holding an entry
        in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
        #2;
        rstn = 1'b0;
        #1;
        chk_dut_idle("async_rst");
        #2;
        rstn = 1'b1;
        @(posedge clk);
        #1;

        // SKID=0: combinational in_ready and 4-bit saturating counter
        s0_in_valid = 1'b1; s0_in_data = 16'hA5A5; s0_in_we = 3'b101; s0_out_ready = 1'b0;
        #1;
        chk("s0 in_ready empty", 256'(s0_in_ready), 256'(1));
        @(posedge clk);
        #1;
        chk("s0 out_valid", 256'(s0_out_valid), 256'(1));
        chk("s0 out_data", 256'(s0_out_data), 256'(16'hA5A5));
        chk("s0 out_we", 256'(s0_out_we), 256'(3'b101));
        chk("s0 in_ready held", 256'(s0_in_ready), 256'(0));
        chk("s0 stall start", 256'(s0_stall_cnt), 256'(0));
        s0_in_data = 16'h1234;
        repeat (3) @(posedge clk);
        #1;
        chk("s0 stall 3", 256'(s0_stall_cnt), 256'(3));
        chk("s0 occupancy", 256'(s0_occupancy), 256'(1));
        chk("s0 data held", 256'(s0_out_data), 256'(16'hA5A5));
        s0_out_ready = 1'b1;
        #1;
        chk("s0 in_ready comb", 256'(s0_in_ready), 256'(1));
        @(posedge clk);
        #1;
        chk("s0 pass-through", 256'(s0_out_data), 256'(16'h1234));
        chk("s0 stall after fire", 256'(s0_stall_cnt), 256'(3));
        s0_in_valid = 1'b0; s0_out_ready = 1'b0;
        repeat (11) @(posedge clk);
        #1;
        chk("s0 stall 14", 256'(s0_stall_cnt), 256'(14));
        repeat (9) @(posedge clk);
        #1;
        chk("s0 stall sat", 256'(s0_stall_cnt), 256'(15));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
